// File: rtl/uart_tx_gen2_pkg.sv
// Shared definitions for the second-generation UART transmitter.
//   tx_state_e : transmit FSM states
//   PAR_*      : parity mode selectors for the PARITY parameter
//   parity_bit : parity over the low nbits of a character for a given mode
package uart_tx_gen2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Even mode returns the XOR of the data bits; odd mode returns its
    // complement so that data plus parity carries an odd number of ones.
    function automatic logic parity_bit(input logic [8:0] data,
                                        input int unsigned nbits,
                                        input int unsigned mode);
        logic x;
        x = 1'b0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i < nbits) x ^= data[i];
        end
        return (mode == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_tx_gen2_fifo.sv
// Synchronous FIFO used as the transmit character queue.
//   clk, rst   : clock, synchronous active-high reset (flushes pointers/count)
//   push       : write strobe for push_data; accepted when not full, or when
//                full with a pop on the same cycle
//   pop        : removes the head entry (ignored when empty)
//   pop_data   : head entry, valid while not empty
//   full/empty : registered occupancy flags
//   count      : registered occupancy, log2(DEPTH)+1 bits
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        pop_ok   = pop && !empty_q;
        // A pop frees the head slot this cycle, so a full FIFO can still
        // take a write when both happen together.
        push_ok  = push && (!full_q || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

endmodule

// File: rtl/uart_tx_gen2.sv
// Parametrised UART transmitter with a small character FIFO.
//   clk, RST    : clock, synchronous active-high reset
//   enable      : permits new frames to start
//   TX_start    : one-cycle strobe queueing data_byte
//   data_byte   : character to queue (DATA_BITS wide)
//   TX          : serial line, idle high
//   TX_busy     : frame in progress or characters queued
//   TX_done     : one-cycle pulse after each completed frame
//   fifo_full   : queue holds FIFO_DEPTH entries
//   fifo_empty  : queue holds no entries
//   tx_overflow : one-cycle pulse when a strobe is dropped on a full queue
module uart_tx_gen2
    import uart_tx_gen2_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 2604,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 enable,
    input  logic                 TX_start,
    input  logic [DATA_BITS-1:0] data_byte,
    output logic                 TX,
    output logic                 TX_busy,
    output logic                 TX_done,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 tx_overflow
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 ovf_q, ovf_d;
    logic                 en_q, en_d;

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full_w;
    logic                 fifo_empty_w;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        cnt_next;
    logic                 push_ok;
    logic                 bit_end;
    logic                 can_start;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (RST),
        .push      (TX_start),
        .push_data (data_byte),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full_w),
        .empty     (fifo_empty_w),
        .count     (fifo_count)
    );

    always_comb begin
        // enable is registered before use, so a frame starts two cycles
        // after enable rises -- the same latency as a strobe into an
        // empty queue.
        en_d      = enable;
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;
        bit_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
        can_start = en_q && !fifo_empty_w;

        case (state_q)
            ST_IDLE: begin
                if (can_start) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    par_d    = parity_bit(9'(fifo_rdata), DATA_BITS, PARITY);
                    state_d  = ST_START;
                    baud_d   = '0;
                    bit_d    = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // Chain straight into the next frame when one is queued.
                        if (can_start) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            par_d    = parity_bit(9'(fifo_rdata), DATA_BITS, PARITY);
                            state_d  = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // TX is registered from the next state so the line changes on the
        // same edge the FSM enters a bit.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase

        push_ok  = TX_start && (!fifo_full_w || fifo_pop);
        cnt_next = fifo_count + CW'(push_ok) - CW'(fifo_pop);
        busy_d   = (state_d != ST_IDLE) || (cnt_next != '0);
        ovf_d    = TX_start && !push_ok;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            en_q    <= en_d;
        end
    end

    assign TX          = tx_q;
    assign TX_busy     = busy_q;
    assign TX_done     = done_q;
    assign fifo_full   = fifo_full_w;
    assign fifo_empty  = fifo_empty_w;
    assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_gen2.sv
module tb_uart_tx_gen2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_en, a_start;
    logic [7:0] a_data;
    logic       a_tx, a_busy, a_done, a_full, a_empty, a_ovf;

    logic       b_en, b_start;
    logic [6:0] b_data;
    logic       b_tx, b_busy, b_done, b_full, b_empty, b_ovf;

    logic       c_en, c_start;
    logic [6:0] c_data;
    logic       c_tx, c_busy, c_done, c_full, c_empty, c_ovf;

    int checks = 0;
    int passed = 0;

    // 8N1, depth 4
    uart_tx_gen2 #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .RST(rst), .enable(a_en), .TX_start(a_start), .data_byte(a_data),
        .TX(a_tx), .TX_busy(a_busy), .TX_done(a_done), .fifo_full(a_full),
        .fifo_empty(a_empty), .tx_overflow(a_ovf));

    // 7 data bits, even parity, 2 stop bits
    uart_tx_gen2 #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .RST(rst), .enable(b_en), .TX_start(b_start), .data_byte(b_data),
        .TX(b_tx), .TX_busy(b_busy), .TX_done(b_done), .fifo_full(b_full),
        .fifo_empty(b_empty), .tx_overflow(b_ovf));

    // 7 data bits, odd parity, 1 stop bit
    uart_tx_gen2 #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .RST(rst), .enable(c_en), .TX_start(c_start), .data_byte(c_data),
        .TX(c_tx), .TX_busy(c_busy), .TX_done(c_done), .fifo_full(c_full),
        .fifo_empty(c_empty), .tx_overflow(c_ovf));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_en = 0; a_start = 0; a_data = '0;
        b_en = 0; b_start = 0; b_data = '0;
        c_en = 0; c_start = 0; c_data = '0;
        tick; tick; tick;
        checks++; if (a_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", a_tx); else passed++;
        checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else passed++;
        checks++; if (a_done !== 1'b0) $display("FAIL reset_done: got %b want 0", a_done); else passed++;
        checks++; if (a_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", a_empty); else passed++;
        checks++; if (a_full !== 1'b0) $display("FAIL reset_full: got %b want 0", a_full); else passed++;
        checks++; if (a_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", a_ovf); else passed++;
        checks++; if (b_tx !== 1'b1 || c_tx !== 1'b1) $display("FAIL reset_tx_bc: got %b%b want 11", b_tx, c_tx); else passed++;
        rst = 1'b0;
        a_en = 1; b_en = 1; c_en = 1;
        tick; tick;
    endtask

    task automatic test_8n1;
        logic [9:0] exp;
        exp = {1'b1, 8'hA5, 1'b0};
        a_data = 8'hA5; a_start = 1'b1;   // cycle N
        tick;                              // N+1
        a_start = 1'b0;
        checks++; if (a_busy !== 1'b1) $display("FAIL 8n1_busy_rise: got %b want 1", a_busy); else passed++;
        checks++; if (a_tx !== 1'b1) $display("FAIL 8n1_tx_n1: got %b want 1", a_tx); else passed++;
        tick;                              // N+2
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (a_tx !== exp[i/4] || a_done !== 1'b0)
                $display("FAIL 8n1_bit cyc %0d: got tx=%b done=%b want tx=%b done=0", i + 2, a_tx, a_done, exp[i/4]);
            else passed++;
            tick;
        end
        // N+42
        checks++; if (a_done !== 1'b1) $display("FAIL 8n1_done: got %b want 1", a_done); else passed++;
        checks++; if (a_busy !== 1'b0) $display("FAIL 8n1_busy_fall: got %b want 0", a_busy); else passed++;
        checks++; if (a_tx !== 1'b1) $display("FAIL 8n1_idle_tx: got %b want 1", a_tx); else passed++;
        tick;
        checks++; if (a_done !== 1'b0) $display("FAIL 8n1_done_width: got %b want 0", a_done); else passed++;
    endtask

    task automatic test_parity;
        logic [10:0] bexp;
        logic [9:0]  cexp;
        bexp = {2'b11, 1'b0, 7'h53, 1'b0};   // four ones -> even parity 0, two stops
        cexp = {1'b1, 1'b1, 7'h53, 1'b0};    // odd parity 1
        b_data = 7'h53; c_data = 7'h53; b_start = 1'b1; c_start = 1'b1;
        tick;
        b_start = 1'b0; c_start = 1'b0;
        tick;                                // N+2
        for (int i = 0; i <= 44; i++) begin
            if (i < 44) begin
                checks++;
                if (b_tx !== bexp[i/4]) $display("FAIL even2_bit cyc %0d: got %b want %b", i + 2, b_tx, bexp[i/4]);
                else passed++;
            end
            if (i < 40) begin
                checks++;
                if (c_tx !== cexp[i/4]) $display("FAIL odd1_bit cyc %0d: got %b want %b", i + 2, c_tx, cexp[i/4]);
                else passed++;
            end
            if (i == 40) begin
                checks++;
                if (c_done !== 1'b1) $display("FAIL odd1_done: got %b want 1", c_done); else passed++;
            end
            if (i == 44) begin
                checks++;
                if (b_done !== 1'b1) $display("FAIL even2_done: got %b want 1", b_done); else passed++;
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d [6];
        logic [9:0] f;
        logic       exp_done;
        int         done_seen;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h3C; d[3] = 8'h81; d[4] = 8'hF0; d[5] = 8'h66;
        done_seen = 0;
        for (int t = 0; t < 204; t++) begin
            if (t < 6) begin
                a_start = 1'b1; a_data = d[t];
            end else begin
                a_start = 1'b0; a_data = 8'h00;
            end
            if (t >= 2 && t < 202) begin
                f = {1'b1, d[(t - 2) / 40], 1'b0};
                checks++;
                if (a_tx !== f[((t - 2) % 40) / 4]) $display("FAIL b2b_bit cyc %0d: got %b want %b", t, a_tx, f[((t - 2) % 40) / 4]);
                else passed++;
            end
            exp_done = (t >= 42 && t <= 202 && ((t - 42) % 40) == 0);
            checks++;
            if (a_done !== exp_done) $display("FAIL b2b_done cyc %0d: got %b want %b", t, a_done, exp_done); else passed++;
            if (a_done === 1'b1) done_seen++;
            checks++;
            if (a_ovf !== (t == 6)) $display("FAIL b2b_ovf cyc %0d: got %b want %b", t, a_ovf, (t == 6)); else passed++;
            if (t == 5) begin
                checks++;
                if (a_full !== 1'b1) $display("FAIL b2b_full: got %b want 1", a_full); else passed++;
            end
            if (t == 202) begin
                checks++;
                if (a_busy !== 1'b0 || a_empty !== 1'b1) $display("FAIL b2b_end: got busy=%b empty=%b want 0 1", a_busy, a_empty);
                else passed++;
            end
            tick;
        end
        checks++;
        if (done_seen != 5) $display("FAIL b2b_done_count: got %0d want 5", done_seen); else passed++;
    endtask

    task automatic test_enable_pause;
        logic [9:0] f1, f2;
        logic       exp_done;
        f1 = {1'b1, 8'h3C, 1'b0};
        f2 = {1'b1, 8'hC3, 1'b0};
        for (int t = 0; t < 94; t++) begin
            a_start = (t < 2);
            a_data  = (t == 0) ? 8'h3C : 8'hC3;
            a_en    = !(t >= 10 && t < 50);
            checks++;
            if (t >= 2 && t < 42) begin
                if (a_tx !== f1[(t - 2) / 4]) $display("FAIL en_f1 cyc %0d: got %b want %b", t, a_tx, f1[(t - 2) / 4]); else passed++;
            end else if (t >= 52 && t < 92) begin
                if (a_tx !== f2[(t - 52) / 4]) $display("FAIL en_f2 cyc %0d: got %b want %b", t, a_tx, f2[(t - 52) / 4]); else passed++;
            end else begin
                if (a_tx !== 1'b1) $display("FAIL en_idle cyc %0d: got %b want 1", t, a_tx); else passed++;
            end
            exp_done = (t == 42 || t == 92);
            checks++;
            if (a_done !== exp_done) $display("FAIL en_done cyc %0d: got %b want %b", t, a_done, exp_done); else passed++;
            if (t == 42) begin
                checks++;
                if (a_busy !== 1'b1 || a_empty !== 1'b0) $display("FAIL en_paused: got busy=%b empty=%b want 1 0", a_busy, a_empty);
                else passed++;
            end
            if (t == 92) begin
                checks++;
                if (a_busy !== 1'b0) $display("FAIL en_end_busy: got %b want 0", a_busy); else passed++;
            end
            tick;
        end
        a_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        for (int t = 0; t < 60; t++) begin
            a_start = (t < 3);
            a_data  = 8'h00;
            rst     = (t == 8);
            if (t == 8) begin
                checks++;
                if (a_tx !== 1'b0 || a_empty !== 1'b0) $display("FAIL rstmid_pre: got tx=%b empty=%b want 0 0", a_tx, a_empty);
                else passed++;
            end
            if (t == 9) begin
                checks++;
                if (a_empty !== 1'b1 || a_busy !== 1'b0 || a_full !== 1'b0)
                    $display("FAIL rstmid_flags: got empty=%b busy=%b full=%b want 1 0 0", a_empty, a_busy, a_full);
                else passed++;
            end
            if (t >= 9) begin
                checks++;
                if (a_tx !== 1'b1 || a_done !== 1'b0) $display("FAIL rstmid_line cyc %0d: got tx=%b done=%b want 1 0", t, a_tx, a_done);
                else passed++;
            end
            tick;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_back_to_back;
        tick; tick;
        test_enable_pause;
        tick; tick;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
